retire_unit: RTL and testbench
==============================

// Module: retire_unit
// PURPOSE
//  Commit stage between the ROB head and the AMT/free list. Each cycle it picks the oldest
//  in-order run of completed head entries (up to C_RT_NUM) and drives the AMT write ports,
//  free-list releases and the ROB pop count. It raises the rollback pulse on a mispredicted
//  branch, blocks commit for a fixed flush window, and latches a sticky halt.
// PARAMETERS
//  C_RT_NUM         `RT_NUM (2)         retire channels; channel 0 = oldest
//  C_ARCH_REG_NUM   `ARCH_REG_NUM (32)  architectural registers; index width AW=$clog2(C_ARCH_REG_NUM)
//  C_TAG_IDX_WIDTH  `TAG_IDX_WIDTH (6)  physical tag width
//  C_FLUSH_CYCLES   2                   cycles commit is blocked after rollback (>=1)
//  C_CNT_WIDTH      64                  retired-instruction counter width
// PORTS
//  clk_i                input   1                  clock
//  rst_n_i              input   1                  async active-low reset
//  rob_head_valid_i     input   C_RT_NUM           head entry j is occupied
//  rob_head_complete_i  input   C_RT_NUM           head entry j has executed
//  rob_head_arch_reg_i  input   C_RT_NUM x AW      destination arch reg; 0 = no destination
//  rob_head_tag_i       input   C_RT_NUM x TAG     new physical tag of entry j
//  rob_head_tag_old_i   input   C_RT_NUM x TAG     previous physical tag of the dest
//  rob_head_mispred_i   input   C_RT_NUM           entry j is a mispredicted branch
//  rob_head_halt_i      input   C_RT_NUM           entry j is a halt instruction
//  rob_head_target_i    input   C_RT_NUM x 32      correct PC for a mispredicted branch
//  retire_num_o         output  $clog2(C_RT_NUM+1) entries the ROB pops at the next edge
//  rob_amt_o            output  ROB_AMT[C_RT_NUM]  {wr_en, arch_reg, phy_reg} per channel to AMT
//  fl_free_valid_o      output  C_RT_NUM           release old tag on channel j
//  fl_free_tag_o        output  C_RT_NUM x TAG     tag released = rob_head_tag_old_i[j]
//  rollback_o           output  1                  pulse: squash pipeline, AMT -> map table
//  redirect_pc_o        output  32                 fetch redirect PC, valid with rollback_o
//  flush_busy_o         output  1                  high while in FLUSH state
//  halt_o               output  1                  sticky, set by a retired halt
//  retired_cnt_o        output  C_CNT_WIDTH        total retired instructions
// BEHAVIOUR
//  - FSM states RUN, FLUSH, HALTED. Reset (rst_n_i low, asynchronous) -> RUN, flush counter 0,
//    retired_cnt_o 0, halt_o 0. While rst_n_i is low, every output is forced to 0.
//  - Commit decision is combinational from the head inputs. Outputs appear in the same cycle,
//    and the ROB pops at the next edge.
//  - In RUN, ret[j] = valid[j] & complete[j] & ret[j-1] & ~mispred[j-1] & ~halt[j-1]
//    (ret[-1] = 1). Retired channels form a contiguous prefix, and retire_num_o = popcount(ret).
//  - In FLUSH and HALTED, ret = 0 and every commit output is 0.
//  - rob_amt_o[j].wr_en = ret[j] & (arch_reg!=0). arch_reg and phy_reg come from the head
//    inputs. fl_free_valid_o[j] equals the same condition.
//  - Rollback: a retiring channel k with mispred & ~halt
//    -> rollback_o=1 and redirect_pc_o=target[k] in that cycle.
//    Channels <=k still drive their AMT writes in that same cycle; the AMT merges them on rollback.
//    Next state is FLUSH with counter = C_FLUSH_CYCLES-1.
//  - FLUSH: counter decrements each cycle. At 0, return to RUN next cycle. rollback_o is 0 here.
//    Inputs are ignored, including those of a ROB being squashed.
//  - Halt: a retiring channel with halt (mispred is ignored on a halt) retires itself; younger
//    channels do not. Next state is HALTED and halt_o=1 from the next cycle.
//    Only reset leaves HALTED.
//  - retired_cnt_o += retire_num_o at each edge, wrapping modulo 2^C_CNT_WIDTH.
//  - redirect_pc_o = 0 whenever rollback_o = 0.
//  - Head entry valid but not complete: it and all younger channels stall (no partial skip).
//  - Reset asserted mid-FLUSH or in HALTED returns to RUN immediately; the flush counter is cleared.
// TESTING
//  - Reset: rst_n_i low with all heads complete -> all outputs 0; release -> retire_num_o=2 same cycle.
//  - Two completed, arch 5/tag 40 (old 5) and arch 0/tag 41 -> wr_en {0,1}, free {0,1} tag 5,
//    retire_num 2, retired_cnt 2 next cycle.
//  - ch0 incomplete, ch1 complete -> retire_num 0, no AMT writes. ch0 complete only -> retire_num 1.
//  - ch0 mispred target 0x1000, ch1 complete -> rollback_o=1, redirect_pc_o=0x1000, retire_num 1.
//    Then flush_busy_o=1 for 2 cycles with no commit, then RUN.
//  - ch0 halt, ch1 complete -> retire_num 1, halt_o=1 next cycle, nothing ever retires again until reset.
//  - Preload retired_cnt near wrap (force) at 2^64-1 and retire 2 -> counter reads 1.

Source files
------------

// File: rtl/retire_unit_if.sv
// rtl/retire_unit_if.sv - ROB head to retire unit bundle plus commit outputs toward AMT and free list.
interface retire_unit_if #(
  parameter int C_RT_NUM        = 2,
  parameter int C_ARCH_REG_NUM  = 32,
  parameter int C_TAG_IDX_WIDTH = 6,
  parameter int C_CNT_WIDTH     = 64
);
  localparam int AW = $clog2(C_ARCH_REG_NUM);
  localparam int NW = $clog2(C_RT_NUM + 1);

  typedef struct packed {
    logic                       wr_en;
    logic [AW-1:0]              arch_reg;
    logic [C_TAG_IDX_WIDTH-1:0] phy_reg;
  } rob_amt_t;

  logic [C_RT_NUM-1:0]                      rob_head_valid_i;
  logic [C_RT_NUM-1:0]                      rob_head_complete_i;
  logic [C_RT_NUM-1:0][AW-1:0]              rob_head_arch_reg_i;
  logic [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0] rob_head_tag_i;
  logic [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0] rob_head_tag_old_i;
  logic [C_RT_NUM-1:0]                      rob_head_mispred_i;
  logic [C_RT_NUM-1:0]                      rob_head_halt_i;
  logic [C_RT_NUM-1:0][31:0]                rob_head_target_i;

  logic [NW-1:0]                            retire_num_o;
  rob_amt_t [C_RT_NUM-1:0]                  rob_amt_o;
  logic [C_RT_NUM-1:0]                      fl_free_valid_o;
  logic [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0] fl_free_tag_o;
  logic                                     rollback_o;
  logic [31:0]                              redirect_pc_o;
  logic                                     flush_busy_o;
  logic                                     halt_o;
  logic [C_CNT_WIDTH-1:0]                   retired_cnt_o;

  modport master (
    output rob_head_valid_i, rob_head_complete_i, rob_head_arch_reg_i, rob_head_tag_i,
           rob_head_tag_old_i, rob_head_mispred_i, rob_head_halt_i, rob_head_target_i,
    input  retire_num_o, rob_amt_o, fl_free_valid_o, fl_free_tag_o, rollback_o,
           redirect_pc_o, flush_busy_o, halt_o, retired_cnt_o
  );

  modport slave (
    input  rob_head_valid_i, rob_head_complete_i, rob_head_arch_reg_i, rob_head_tag_i,
           rob_head_tag_old_i, rob_head_mispred_i, rob_head_halt_i, rob_head_target_i,
    output retire_num_o, rob_amt_o, fl_free_valid_o, fl_free_tag_o, rollback_o,
           redirect_pc_o, flush_busy_o, halt_o, retired_cnt_o
  );
endinterface

// File: rtl/retire_unit.sv
// rtl/retire_unit.sv - In-order commit of the ROB head with rollback flush window and sticky halt.
module retire_unit #(
  parameter int C_RT_NUM       = 2,
  parameter int C_ARCH_REG_NUM = 32,
  parameter int C_FLUSH_CYCLES = 2,
  parameter int C_CNT_WIDTH    = 64
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  retire_unit_if.slave   bus
);
  localparam int AW = $clog2(C_ARCH_REG_NUM);
  localparam int NW = $clog2(C_RT_NUM + 1);
  localparam int FW = (C_FLUSH_CYCLES > 1) ? $clog2(C_FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [FW-1:0]          r_flush_cnt;
  logic [FW-1:0]          w_flush_nxt;
  logic [C_CNT_WIDTH-1:0] r_retired_cnt;

  logic                   w_commit_en;
  logic [C_RT_NUM-1:0]    w_ret;
  logic [NW-1:0]          w_num;
  logic                   w_rollback;
  logic [31:0]            w_redirect;
  logic                   w_halt_ret;

  // Outputs are held at zero during reset, so gating includes rst_n_i directly.
  assign w_commit_en = rst_n_i && (r_state == RUN);

  // Retire chain: an entry retires only if every older one did and was not a
  // mispredict or halt; halt takes priority over mispredict on the same entry.
  always_comb begin
    logic w_prev_ok;
    w_prev_ok  = w_commit_en;
    w_ret      = '0;
    w_num      = '0;
    w_rollback = 1'b0;
    w_redirect = '0;
    w_halt_ret = 1'b0;
    for (int j = 0; j < C_RT_NUM; j++) begin
      w_ret[j]  = w_prev_ok && bus.rob_head_valid_i[j] && bus.rob_head_complete_i[j];
      w_num     = w_num + NW'(w_ret[j]);
      if (w_ret[j] && bus.rob_head_halt_i[j]) begin
        w_halt_ret = 1'b1;
      end else if (w_ret[j] && bus.rob_head_mispred_i[j]) begin
        w_rollback = 1'b1;
        w_redirect = bus.rob_head_target_i[j];
      end
      w_prev_ok = w_ret[j] && !bus.rob_head_mispred_i[j] && !bus.rob_head_halt_i[j];
    end
  end

  always_comb begin
    bus.rob_amt_o       = '0;
    bus.fl_free_valid_o = '0;
    bus.fl_free_tag_o   = '0;
    for (int j = 0; j < C_RT_NUM; j++) begin
      if (w_commit_en) begin
        bus.rob_amt_o[j].arch_reg = bus.rob_head_arch_reg_i[j];
        bus.rob_amt_o[j].phy_reg  = bus.rob_head_tag_i[j];
        bus.fl_free_tag_o[j]      = bus.rob_head_tag_old_i[j];
      end
      bus.rob_amt_o[j].wr_en = w_ret[j] && (bus.rob_head_arch_reg_i[j] != {AW{1'b0}});
      bus.fl_free_valid_o[j] = w_ret[j] && (bus.rob_head_arch_reg_i[j] != {AW{1'b0}});
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_flush_nxt = r_flush_cnt;
    case (r_state)
      RUN: begin
        if (w_halt_ret) begin
          w_state_nxt = HALTED;
        end else if (w_rollback) begin
          w_state_nxt = FLUSH;
          w_flush_nxt = FW'(C_FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (r_flush_cnt == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_flush_nxt = r_flush_cnt - 1'b1;
        end
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= RUN;
      r_flush_cnt   <= '0;
      r_retired_cnt <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_flush_cnt   <= w_flush_nxt;
      r_retired_cnt <= r_retired_cnt + C_CNT_WIDTH'(w_num);
    end
  end

  assign bus.retire_num_o  = w_num;
  assign bus.rollback_o    = w_rollback;
  assign bus.redirect_pc_o = w_redirect;
  assign bus.flush_busy_o  = rst_n_i && (r_state == FLUSH);
  assign bus.halt_o        = rst_n_i && (r_state == HALTED);
  assign bus.retired_cnt_o = r_retired_cnt;
endmodule

// File: tb/tb_retire_unit.sv
// tb/tb_retire_unit.sv - Scoreboard bench for retire_unit commit, rollback, halt and counter wrap.
module tb_retire_unit;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  retire_unit_if #(.C_RT_NUM(2), .C_ARCH_REG_NUM(32), .C_TAG_IDX_WIDTH(6), .C_CNT_WIDTH(64)) bus ();

  retire_unit #(.C_RT_NUM(2), .C_ARCH_REG_NUM(32), .C_FLUSH_CYCLES(2), .C_CNT_WIDTH(64)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0]  num;
    logic [1:0]  wr;
    logic [1:0]  fv;
    logic        roll;
    logic [31:0] pc;
    logic        busy;
    logic        halt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] m_cnt    = '0;
  logic [4:0]  r_a0, r_a1;
  logic [5:0]  r_t0, r_t1, r_o0, r_o1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] num, input logic [1:0] wr, input logic [1:0] fv,
                              input logic roll, input logic [31:0] pc, input logic busy,
                              input logic halt);
    exp_t e;
    e.num = num; e.wr = wr; e.fv = fv; e.roll = roll; e.pc = pc; e.busy = busy; e.halt = halt;
    return e;
  endfunction

  task automatic set_regs(input logic [4:0] a0, input logic [4:0] a1, input logic [5:0] t0,
                          input logic [5:0] t1, input logic [5:0] o0, input logic [5:0] o1,
                          input logic [31:0] pc0, input logic [31:0] pc1);
    r_a0 = a0; r_a1 = a1; r_t0 = t0; r_t1 = t1; r_o0 = o0; r_o1 = o1;
    bus.rob_head_arch_reg_i[0] = a0;
    bus.rob_head_arch_reg_i[1] = a1;
    bus.rob_head_tag_i[0]      = t0;
    bus.rob_head_tag_i[1]      = t1;
    bus.rob_head_tag_old_i[0]  = o0;
    bus.rob_head_tag_old_i[1]  = o1;
    bus.rob_head_target_i[0]   = pc0;
    bus.rob_head_target_i[1]   = pc1;
  endtask

  // Called at a falling edge: drive, queue the expectation, compare, then clock once.
  task automatic step(input string tag, input logic [1:0] v, input logic [1:0] c,
                      input logic [1:0] m, input logic [1:0] h, input exp_t e);
    exp_t x;
    bus.rob_head_valid_i    = v;
    bus.rob_head_complete_i = c;
    bus.rob_head_mispred_i  = m;
    bus.rob_head_halt_i     = h;
    sb_q.push_back(e);
    #1;
    x = sb_q.pop_front();
    check({tag, ".num"},  64'(bus.retire_num_o), 64'(x.num));
    check({tag, ".wr"},   64'({bus.rob_amt_o[1].wr_en, bus.rob_amt_o[0].wr_en}), 64'(x.wr));
    check({tag, ".fv"},   64'(bus.fl_free_valid_o), 64'(x.fv));
    check({tag, ".roll"}, 64'(bus.rollback_o), 64'(x.roll));
    check({tag, ".pc"},   64'(bus.redirect_pc_o), 64'(x.pc));
    check({tag, ".busy"}, 64'(bus.flush_busy_o), 64'(x.busy));
    check({tag, ".halt"}, 64'(bus.halt_o), 64'(x.halt));
    check({tag, ".cnt"},  bus.retired_cnt_o, m_cnt);
    if (x.wr[0]) begin
      check({tag, ".arch0"}, 64'(bus.rob_amt_o[0].arch_reg), 64'(r_a0));
      check({tag, ".phy0"},  64'(bus.rob_amt_o[0].phy_reg), 64'(r_t0));
      check({tag, ".ftag0"}, 64'(bus.fl_free_tag_o[0]), 64'(r_o0));
    end
    if (x.wr[1]) begin
      check({tag, ".arch1"}, 64'(bus.rob_amt_o[1].arch_reg), 64'(r_a1));
      check({tag, ".ftag1"}, 64'(bus.fl_free_tag_o[1]), 64'(r_o1));
    end
    @(posedge clk_i);
    m_cnt = m_cnt + 64'(x.num);
    @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".num"},  64'(bus.retire_num_o), 64'd0);
    check({tag, ".amt"},  64'(bus.rob_amt_o), 64'd0);
    check({tag, ".fv"},   64'(bus.fl_free_valid_o), 64'd0);
    check({tag, ".ftag"}, 64'(bus.fl_free_tag_o), 64'd0);
    check({tag, ".roll"}, 64'(bus.rollback_o), 64'd0);
    check({tag, ".pc"},   64'(bus.redirect_pc_o), 64'd0);
    check({tag, ".busy"}, 64'(bus.flush_busy_o), 64'd0);
    check({tag, ".halt"}, 64'(bus.halt_o), 64'd0);
    check({tag, ".cnt"},  bus.retired_cnt_o, 64'd0);
  endtask

  initial begin
    set_regs(5'd3, 5'd4, 6'd10, 6'd11, 6'd1, 6'd2, 32'h0, 32'h0);
    bus.rob_head_valid_i    = 2'b11;
    bus.rob_head_complete_i = 2'b11;
    bus.rob_head_mispred_i  = 2'b00;
    bus.rob_head_halt_i     = 2'b00;
    #2;
    check_reset_outputs("rst");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    step("rel",    2'b11, 2'b11, 2'b00, 2'b00, mk(2'd2, 2'b11, 2'b11, 1'b0, 32'h0, 1'b0, 1'b0));
    set_regs(5'd5, 5'd0, 6'd40, 6'd41, 6'd5, 6'd6, 32'h0, 32'h0);
    step("two",    2'b11, 2'b11, 2'b00, 2'b00, mk(2'd2, 2'b01, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0));
    set_regs(5'd3, 5'd4, 6'd12, 6'd13, 6'd7, 6'd8, 32'h0, 32'h0);
    step("stall0", 2'b11, 2'b10, 2'b00, 2'b00, mk(2'd0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0));
    step("only0",  2'b11, 2'b01, 2'b00, 2'b00, mk(2'd1, 2'b01, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0));
    step("empty0", 2'b10, 2'b11, 2'b00, 2'b00, mk(2'd0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0));

    set_regs(5'd2, 5'd7, 6'd20, 6'd21, 6'd9, 6'd14, 32'h1000, 32'h2000);
    step("mis0",   2'b11, 2'b11, 2'b01, 2'b00, mk(2'd1, 2'b01, 2'b01, 1'b1, 32'h1000, 1'b0, 1'b0));
    step("fl1",    2'b11, 2'b11, 2'b01, 2'b00, mk(2'd0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0));
    step("fl2",    2'b11, 2'b11, 2'b00, 2'b00, mk(2'd0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0));
    step("run",    2'b11, 2'b11, 2'b00, 2'b00, mk(2'd2, 2'b11, 2'b11, 1'b0, 32'h0, 1'b0, 1'b0));
    step("mis1",   2'b11, 2'b11, 2'b10, 2'b00, mk(2'd2, 2'b11, 2'b11, 1'b1, 32'h2000, 1'b0, 1'b0));
    step("fl1b",   2'b11, 2'b11, 2'b00, 2'b00, mk(2'd0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0));
    step("fl2b",   2'b11, 2'b11, 2'b00, 2'b00, mk(2'd0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0));

    step("halt",   2'b11, 2'b11, 2'b01, 2'b01, mk(2'd1, 2'b01, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0));
    step("hld1",   2'b11, 2'b11, 2'b00, 2'b00, mk(2'd0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1));
    step("hld2",   2'b11, 2'b11, 2'b00, 2'b00, mk(2'd0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1));

    rst_n_i = 1'b0;
    #1;
    check_reset_outputs("rst_halt");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    m_cnt   = '0;
    step("after",  2'b11, 2'b11, 2'b00, 2'b00, mk(2'd2, 2'b11, 2'b11, 1'b0, 32'h0, 1'b0, 1'b0));

    force dut.r_retired_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_retired_cnt;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    step("wrap",   2'b11, 2'b11, 2'b00, 2'b00, mk(2'd2, 2'b11, 2'b11, 1'b0, 32'h0, 1'b0, 1'b0));
    #1;
    check("cnt_wrap", bus.retired_cnt_o, 64'd1);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
